// File: rtl/sprite_overlay.sv
// Draws one ROM-backed sprite over a background colour with colour keying, integer scale and blink.
// Position/scale writes are shadowed and only take effect at the frame commit point, so a frame never tears.
module sprite_overlay #(
   parameter int          W          = 78,
   parameter int          H          = 11,
   parameter int          ROW_W      = 4,
   parameter int          COL_W      = 7,
   parameter int          X0         = 355,
   parameter int          Y0         = 277,
   parameter logic [11:0] KEY        = 12'hFFF,
   parameter int          FRAME_LINE = 480,
   parameter int          BLINK_BIT  = 5,
   parameter int          FCNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bright,
   input  logic             en,
   input  logic [9:0]       hCount,
   input  logic [9:0]       vCount,
   input  logic [9:0]       x_in,
   input  logic [9:0]       y_in,
   input  logic [1:0]       scale_in,
   input  logic             pos_we,
   input  logic             blink_en,
   input  logic [11:0]      background,
   output logic [ROW_W-1:0] rom_row,
   output logic [COL_W-1:0] rom_col,
   input  logic [11:0]      rom_data,
   output logic             frame_tick,
   output logic [11:0]      rgb
);

   logic [9:0]        x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
   logic [1:0]        scale_q, scale_d, pscale_q, pscale_d;
   logic              pend_q, pend_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              tick_q, hit_q, bright_q;
   logic [11:0]       bg_q, rgb_q, rgb_d;

   logic              tick_c, vis_c, hit_c;
   logic [10:0]       hc11, vc11, x11, y11, sx, sy;
   logic [9:0]        dx, dy;

   assign tick_c = (hCount == 10'd0) && (vCount == 10'(FRAME_LINE));
   assign vis_c  = !blink_en || !fcnt_q[BLINK_BIT];

   // 11-bit compare so a sprite hanging past column/line 1023 clips instead of wrapping
   assign hc11 = {1'b0, hCount};
   assign vc11 = {1'b0, vCount};
   assign x11  = {1'b0, x_q};
   assign y11  = {1'b0, y_q};
   assign sx   = 11'(W) << scale_q;
   assign sy   = 11'(H) << scale_q;

   assign hit_c = en && vis_c && (hc11 >= x11) && (hc11 < x11 + sx)
                  && (vc11 >= y11) && (vc11 < y11 + sy);

   assign dx      = hCount - x_q;
   assign dy      = vCount - y_q;
   assign rom_col = COL_W'(dx >> scale_q);
   assign rom_row = ROW_W'(dy >> scale_q);

   always_comb begin
      px_d     = px_q;
      py_d     = py_q;
      pscale_d = pscale_q;
      pend_d   = pend_q;
      x_d      = x_q;
      y_d      = y_q;
      scale_d  = scale_q;
      fcnt_d   = fcnt_q;
      if (pos_we) begin
         px_d     = x_in;
         py_d     = y_in;
         pscale_d = scale_in;
         pend_d   = 1'b1;
      end
      if (tick_c) begin
         fcnt_d = fcnt_q + FCNT_W'(1);
         // a write landing on the commit cycle bypasses the shadow registers
         if (pos_we) begin
            x_d     = x_in;
            y_d     = y_in;
            scale_d = scale_in;
            pend_d  = 1'b0;
         end else if (pend_q) begin
            x_d     = px_q;
            y_d     = py_q;
            scale_d = pscale_q;
            pend_d  = 1'b0;
         end
      end
   end

   always_comb begin
      rgb_d = bg_q;
      if (!bright_q)
         rgb_d = 12'h000;
      else if (hit_q && (rom_data != KEY))
         rgb_d = rom_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q      <= 10'(X0);
         y_q      <= 10'(Y0);
         scale_q  <= 2'd0;
         px_q     <= 10'(X0);
         py_q     <= 10'(Y0);
         pscale_q <= 2'd0;
         pend_q   <= 1'b0;
         fcnt_q   <= '0;
         tick_q   <= 1'b0;
         hit_q    <= 1'b0;
         bright_q <= 1'b0;
         bg_q     <= 12'h000;
         rgb_q    <= 12'h000;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         scale_q  <= scale_d;
         px_q     <= px_d;
         py_q     <= py_d;
         pscale_q <= pscale_d;
         pend_q   <= pend_d;
         fcnt_q   <= fcnt_d;
         tick_q   <= tick_c;
         hit_q    <= hit_c;
         bright_q <= bright;
         bg_q     <= background;
         rgb_q    <= rgb_d;
      end
   end

   assign frame_tick = tick_q;
   assign rgb        = rgb_q;

endmodule
